ucode_sequencer: RTL and testbench



---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/ucode_rom.sv | 61 ++++++
 rtl/ucode_sequencer.sv | 111 +++++++++++
 tb/tb_ucode_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the microcode control unit.
//   - opcode encodings
//   - control-word bit indices and single-bit masks (bit 15 = HLT ... bit 0 = FI)
//   - default number of T-states per instruction
//   - the two opcode-independent fetch words
package ctrl_pkg;

  // Opcode encodings (upper nibble of the instruction register)
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control-word bit positions
  localparam int B_HLT = 15;
  localparam int B_MI  = 14;
  localparam int B_RI  = 13;
  localparam int B_RO  = 12;
  localparam int B_IO  = 11;
  localparam int B_II  = 10;
  localparam int B_AI  = 9;
  localparam int B_AO  = 8;
  localparam int B_EO  = 7;
  localparam int B_SU  = 6;
  localparam int B_BI  = 5;
  localparam int B_OI  = 4;
  localparam int B_CE  = 3;
  localparam int B_CO  = 2;
  localparam int B_J   = 1;
  localparam int B_FI  = 0;

  // Single-bit masks so microcode words read as OR-ed strobe names
  localparam logic [15:0] C_HLT = 16'h0001 << B_HLT;
  localparam logic [15:0] C_MI  = 16'h0001 << B_MI;
  localparam logic [15:0] C_RI  = 16'h0001 << B_RI;
  localparam logic [15:0] C_RO  = 16'h0001 << B_RO;
  localparam logic [15:0] C_IO  = 16'h0001 << B_IO;
  localparam logic [15:0] C_II  = 16'h0001 << B_II;
  localparam logic [15:0] C_AI  = 16'h0001 << B_AI;
  localparam logic [15:0] C_AO  = 16'h0001 << B_AO;
  localparam logic [15:0] C_EO  = 16'h0001 << B_EO;
  localparam logic [15:0] C_SU  = 16'h0001 << B_SU;
  localparam logic [15:0] C_BI  = 16'h0001 << B_BI;
  localparam logic [15:0] C_OI  = 16'h0001 << B_OI;
  localparam logic [15:0] C_CE  = 16'h0001 << B_CE;
  localparam logic [15:0] C_CO  = 16'h0001 << B_CO;
  localparam logic [15:0] C_J   = 16'h0001 << B_J;
  localparam logic [15:0] C_FI  = 16'h0001 << B_FI;

  localparam int STEPS_DEFAULT = 5;

  // Fetch words: PC -> MAR, then RAM -> IR with PC increment
  localparam logic [15:0] FETCH0 = 16'h4004;
  localparam logic [15:0] FETCH1 = 16'h1408;

endpackage

// File: rtl/ucode_rom.sv
// ucode_rom: purely combinational microcode table.
// Ports:
//   opcode [3:0] in  - decoded opcode
//   step   [2:0] in  - current T-state
//   cf, zf       in  - latched flags (select taken/untaken conditional jumps)
//   word  [15:0] out - control word for this opcode/step
module ucode_rom
  import ctrl_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [2:0]  step,
  input  logic        cf,
  input  logic        zf,
  output logic [15:0] word
);

  // Fetch steps are opcode-independent; execute steps 2..4 come from the table
  always_comb begin
    word = 16'h0000;
    if (step == 3'd0) begin
      word = FETCH0;
    end else if (step == 3'd1) begin
      word = FETCH1;
    end else begin
      case (opcode)
        OP_LDA: begin
          case (step)
            3'd2:    word = C_IO | C_MI;
            3'd3:    word = C_RO | C_AI;
            default: word = 16'h0000;
          endcase
        end
        OP_ADD, OP_SUB: begin
          case (step)
            3'd2:    word = C_IO | C_MI;
            3'd3:    word = C_RO | C_BI;
            3'd4:    word = (opcode == OP_SUB) ? (C_EO | C_AI | C_SU | C_FI)
                                               : (C_EO | C_AI | C_FI);
            default: word = 16'h0000;
          endcase
        end
        OP_STA: begin
          case (step)
            3'd2:    word = C_IO | C_MI;
            3'd3:    word = C_AO | C_RI;
            default: word = 16'h0000;
          endcase
        end
        OP_LDI: word = (step == 3'd2) ? (C_IO | C_AI) : 16'h0000;
        OP_JMP: word = (step == 3'd2) ? (C_IO | C_J) : 16'h0000;
        // Untaken conditional jumps produce an all-zero step 2, which ends the instruction
        OP_JC:  word = ((step == 3'd2) && cf) ? (C_IO | C_J) : 16'h0000;
        OP_JZ:  word = ((step == 3'd2) && zf) ? (C_IO | C_J) : 16'h0000;
        OP_OUT: word = (step == 3'd2) ? (C_AO | C_OI) : 16'h0000;
        OP_HLT: word = (step == 3'd2) ? C_HLT : 16'h0000;
        default: word = 16'h0000;
      endcase
    end
  end

endmodule

// File: rtl/ucode_sequencer.sv
// ucode_sequencer: microcode control unit of the 8-bit CPU.
// Holds the T-state counter, carry/zero flags and halt latch; decodes the
// opcode in the instruction register into the 16-bit control word.
// Ports:
//   clk              in  - rising-edge clock
//   reset            in  - synchronous, active-high
//   instr [N-1:0]    in  - instruction register; opcode = instr[N-1:N-OP]
//   alu_carry/zero   in  - ALU status, captured when FI is asserted
//   ctrl [15:0]      out - control word {HLT,MI,RI,RO,IO,II,AI,AO,EO,SU,BI,OI,CE,CO,J,FI}
//   step [2:0]       out - current T-state
//   cf, zf           out - latched flags
//   halted           out - halt latch
module ucode_sequencer
  import ctrl_pkg::*;
#(
  parameter int N     = 8,
  parameter int OP    = 4,
  parameter int STEPS = STEPS_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] instr,
  input  logic         alu_carry,
  input  logic         alu_zero,
  output logic [15:0]  ctrl,
  output logic [2:0]   step,
  output logic         cf,
  output logic         zf,
  output logic         halted
);

  localparam logic [2:0] STEP_LAST = 3'(STEPS - 1);

  logic [2:0]  step_q, step_d;
  logic        cf_q, cf_d;
  logic        zf_q, zf_d;
  logic        halted_q, halted_d;
  logic [15:0] rom_word;
  logic        unused_operand;

  // Operand bits are consumed by the datapath, not by the sequencer
  assign unused_operand = ^instr[N-OP-1:0];

  ucode_rom u_rom (
    .opcode (instr[N-1:N-OP]),
    .step   (step_q),
    .cf     (cf_q),
    .zf     (zf_q),
    .word   (rom_word)
  );

  // A halted CPU issues no strobes at all
  always_comb begin
    ctrl = 16'h0000;
    if (halted_q) begin
      ctrl = 16'h0000;
    end else begin
      ctrl = rom_word;
    end
  end

  // Next-state: flag capture, halt latch and step sequencing
  always_comb begin
    step_d   = step_q;
    cf_d     = cf_q;
    zf_d     = zf_q;
    halted_d = halted_q;
    if (reset) begin
      step_d   = 3'd0;
      cf_d     = 1'b0;
      zf_d     = 1'b0;
      halted_d = 1'b0;
    end else begin
      if (ctrl[B_FI]) begin
        cf_d = alu_carry;
        zf_d = alu_zero;
      end else begin
        cf_d = cf_q;
        zf_d = zf_q;
      end
      if (halted_q) begin
        step_d = step_q;
      end else if (ctrl[B_HLT]) begin
        // Freeze on the HLT step itself so the halted CPU shows where it stopped
        halted_d = 1'b1;
        step_d   = step_q;
      end else if ((step_q >= 3'd2) && (ctrl == 16'h0000)) begin
        // First empty execute step is the single idle cycle ending the instruction
        step_d = 3'd0;
      end else if (step_q == STEP_LAST) begin
        step_d = 3'd0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    step_q   <= step_d;
    cf_q     <= cf_d;
    zf_q     <= zf_d;
    halted_q <= halted_d;
  end

  assign step   = step_q;
  assign cf     = cf_q;
  assign zf     = zf_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer: directed plus randomized instruction stream, checked
// every cycle against an instruction-level reference model.
module tb_ucode_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  instr;
  logic        alu_carry;
  logic        alu_zero;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        cf;
  logic        zf;
  logic        halted;

  int total = 0;
  int fails = 0;
  bit m_cf = 1'b0;
  bit m_zf = 1'b0;
  bit m_halted = 1'b0;

  ucode_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .alu_carry (alu_carry),
    .alu_zero  (alu_zero),
    .ctrl      (ctrl),
    .step      (step),
    .cf        (cf),
    .zf        (zf),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Execute words for steps 2,3,4 of each instruction, straight from the opcode table
  function automatic logic [47:0] prog(input logic [3:0] op, input bit fc, input bit fz);
    case (op)
      4'h1:    return {16'h4800, 16'h1200, 16'h0000};
      4'h2:    return {16'h4800, 16'h1020, 16'h0281};
      4'h3:    return {16'h4800, 16'h1020, 16'h02C1};
      4'h4:    return {16'h4800, 16'h2100, 16'h0000};
      4'h5:    return {16'h0A00, 16'h0000, 16'h0000};
      4'h6:    return {16'h0802, 16'h0000, 16'h0000};
      4'h7:    return fc ? {16'h0802, 16'h0000, 16'h0000} : 48'h0;
      4'h8:    return fz ? {16'h0802, 16'h0000, 16'h0000} : 48'h0;
      4'hE:    return {16'h0110, 16'h0000, 16'h0000};
      4'hF:    return {16'h8000, 16'h0000, 16'h0000};
      default: return 48'h0;
    endcase
  endfunction

  task automatic check_state(input int exp_step, input logic [15:0] exp_ctrl);
    chk("step", {13'h0, step}, 16'(exp_step));
    chk("ctrl", ctrl, exp_ctrl);
    chk("cf", {15'h0, cf}, {15'h0, m_cf});
    chk("zf", {15'h0, zf}, {15'h0, m_zf});
    chk("halted", {15'h0, halted}, {15'h0, m_halted});
  endtask

  // Hold reset for two cycles; state must already be cleared before release
  task automatic do_reset();
    reset = 1'b1;
    alu_carry = 1'($urandom_range(0, 1));
    alu_zero  = 1'($urandom_range(0, 1));
    repeat (2) @(negedge clk);
    m_cf = 1'b0;
    m_zf = 1'b0;
    m_halted = 1'b0;
    #1;
    check_state(0, 16'h4004);
    reset = 1'b0;
  endtask

  // Run one instruction cycle by cycle; cin/zin < 0 means random ALU status.
  // abort_at >= 0 asserts reset during that step.
  task automatic run_instr(input logic [3:0] op, input int cin, input int zin, input int abort_at);
    logic [47:0] p;
    logic [15:0] w [3];
    int n;
    int len;
    bit c;
    bit z;
    instr = {op, 4'($urandom_range(0, 15))};
    p = prog(op, m_cf, m_zf);
    w[0] = p[47:32];
    w[1] = p[31:16];
    w[2] = p[15:0];
    n = 0;
    while (n < 3 && w[n] != 16'h0000) n++;
    // Nonzero words, plus one idle step unless the last word sits in the final step
    len = (2 + n < 5) ? 3 + n : 5;
    for (int t = 0; t < len; t++) begin
      logic [15:0] e;
      c = (cin < 0) ? 1'($urandom_range(0, 1)) : cin[0];
      z = (zin < 0) ? 1'($urandom_range(0, 1)) : zin[0];
      alu_carry = c;
      alu_zero  = z;
      if (t == abort_at) reset = 1'b1;
      #1;
      e = (t == 0) ? 16'h4004 : (t == 1) ? 16'h1408 : (t - 2 < n) ? w[t-2] : 16'h0000;
      check_state(t, e);
      if (t == abort_at) begin
        @(negedge clk);
        reset = 1'b0;
        m_cf = 1'b0;
        m_zf = 1'b0;
        return;
      end
      if (e[0]) begin
        m_cf = c;
        m_zf = z;
      end
      if (e[15]) begin
        m_halted = 1'b1;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] rop;
    reset = 1'b1;
    instr = 8'h00;
    alu_carry = 1'b0;
    alu_zero = 1'b0;
    @(negedge clk);
    do_reset();

    run_instr(4'h0, -1, -1, -1);   // NOP: 3 cycles
    run_instr(4'h1, -1, -1, -1);   // LDA: flags untouched
    run_instr(4'h2, 1, 0, -1);     // ADD: cf=1, zf=0
    run_instr(4'h3, 0, 1, -1);     // SUB: cf=0, zf=1
    run_instr(4'h7, -1, -1, -1);   // JC untaken
    run_instr(4'h8, -1, -1, -1);   // JZ taken
    run_instr(4'h2, 1, 0, -1);
    run_instr(4'h7, -1, -1, -1);   // JC taken
    run_instr(4'h8, -1, -1, -1);   // JZ untaken
    run_instr(4'h4, -1, -1, -1);
    run_instr(4'h5, -1, -1, -1);
    run_instr(4'h6, -1, -1, -1);
    run_instr(4'hE, -1, -1, -1);
    run_instr(4'hB, -1, -1, -1);   // unassigned opcode behaves as NOP

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 14));
      run_instr(rop, -1, -1, -1);
    end

    // Reset at step 4 of ADD with FI active: flags must not load
    run_instr(4'h2, 1, 1, -1);
    run_instr(4'h2, 1, 1, 4);
    run_instr(4'h0, -1, -1, -1);

    // Halt: step freezes at 2, no strobes, flags hold
    run_instr(4'h2, 1, 1, -1);
    run_instr(4'hF, -1, -1, -1);
    for (int i = 0; i < 10; i++) begin
      instr = 8'($urandom_range(0, 255));
      alu_carry = 1'($urandom_range(0, 1));
      alu_zero  = 1'($urandom_range(0, 1));
      #1;
      check_state(2, 16'h0000);
      @(negedge clk);
    end
    do_reset();
    run_instr(4'h5, -1, -1, -1);
    run_instr(4'h3, 0, 0, -1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
